// File: rtl/sensor_input_conditioner.sv
// Input front end for the irrigation controller: synchronizes and debounces six raw
// field inputs, pulses per-channel change flags and filters tank-level inconsistencies.
module sensor_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw_i,
    output logic [5:0] stable_o,
    output logic [5:0] change_o,
    output logic       level_fault_o
);

    localparam int                FCNT_W     = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FAULT_LAST = FCNT_W'(FAULT_CYCLES - 1);

    // Two-flop synchronizer; only s2_reg is allowed to reach the debounce logic.
    logic [5:0] s1_reg;
    logic [5:0] s2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= raw_i;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_reg;
            logic             stable_next;
            logic             change_reg;
            logic             change_next;

            // Any cycle where s2 agrees with the stable value restarts the run.
            always_comb begin
                cnt_next    = cnt_reg;
                stable_next = stable_reg;
                change_next = 1'b0;
                if (s2_reg[gi] == stable_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next    = '0;
                    stable_next = s2_reg[gi];
                    change_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                    change_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                    change_reg <= change_next;
                end
            end

            assign stable_o[gi] = stable_reg;
            assign change_o[gi] = change_reg;
        end
    endgenerate

    // Level switches must nest: high implies middle implies low.
    logic              level_inconsistent;
    logic [FCNT_W-1:0] fcnt_reg;
    logic [FCNT_W-1:0] fcnt_next;
    logic              fault_reg;
    logic              fault_next;

    assign level_inconsistent = (stable_o[2] & ~stable_o[1])
                              | (stable_o[1] & ~stable_o[0])
                              | (stable_o[2] & ~stable_o[0]);

    always_comb begin
        fcnt_next  = fcnt_reg;
        fault_next = fault_reg;
        if (!level_inconsistent) begin
            fcnt_next  = '0;
            fault_next = 1'b0;
        end else if (fcnt_reg == FAULT_LAST) begin
            fault_next = 1'b1;
        end else begin
            fcnt_next = fcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            fcnt_reg  <= fcnt_next;
            fault_reg <= fault_next;
        end
    end

    assign level_fault_o = fault_reg;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4, FAULT_CYCLES=3:
// one vector per clock edge, expected outputs sampled 1 ns after the edge.
module tb_sensor_input_conditioner;

    logic       clk;
    logic       rst;
    logic [5:0] raw_i;
    logic [5:0] stable_o;
    logic [5:0] change_o;
    logic       level_fault_o;

    int checks   = 0;
    int failures = 0;

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .FAULT_CYCLES   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_i        (raw_i),
        .stable_o     (stable_o),
        .change_o     (change_o),
        .level_fault_o(level_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] raw;
        logic [5:0] exp_stable;
        logic [5:0] exp_change;
        logic       exp_fault;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add_run(input int n, input logic r, input logic [5:0] raw,
                           input logic [5:0] st, input logic [5:0] ch, input logic f);
        for (int i = 0; i < n; i++) begin
            vecs[nvec].rst        = r;
            vecs[nvec].raw        = raw;
            vecs[nvec].exp_stable = st;
            vecs[nvec].exp_change = ch;
            vecs[nvec].exp_fault  = f;
            nvec++;
        end
    endtask

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Apply inputs, take one edge, sample just after it.
    task automatic step(input logic r, input logic [5:0] raw);
        rst   = r;
        raw_i = raw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bool_dummy: begin end
        rst   = 1'b1;
        raw_i = 6'h00;

        // Reset with inputs high, then release.
        add_run(2, 1'b1, 6'h3F, 6'h00, 6'h00, 1'b0);
        add_run(5, 1'b0, 6'h3F, 6'h00, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 1'b0);
        add_run(1, 1'b0, 6'h3F, 6'h3F, 6'h00, 1'b0);
        // Everything back to zero (pattern jumps 111 -> 000, both consistent).
        add_run(5, 1'b0, 6'h00, 6'h3F, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h00, 6'h00, 6'h3F, 1'b0);
        add_run(1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0);
        // Clean step on soil humidity.
        add_run(5, 1'b0, 6'h08, 6'h00, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h08, 6'h08, 6'h08, 1'b0);
        add_run(1, 1'b0, 6'h08, 6'h08, 6'h00, 1'b0);
        // Temperature bounce: 3 high, 1 low, then held high.
        add_run(3, 1'b0, 6'h28, 6'h08, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h08, 6'h08, 6'h00, 1'b0);
        add_run(5, 1'b0, 6'h28, 6'h08, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h28, 6'h28, 6'h20, 1'b0);
        add_run(1, 1'b0, 6'h28, 6'h28, 6'h00, 1'b0);
        // High level only: inconsistent 100, fault after 3 edges.
        add_run(5, 1'b0, 6'h2C, 6'h28, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h2C, 6'h2C, 6'h04, 1'b0);
        add_run(2, 1'b0, 6'h2C, 6'h2C, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h2C, 6'h2C, 6'h00, 1'b1);
        // Fill the tank to 111: fault clears the edge after stable reaches 111.
        add_run(5, 1'b0, 6'h2F, 6'h2C, 6'h00, 1'b1);
        add_run(1, 1'b0, 6'h2F, 6'h2F, 6'h03, 1'b1);
        add_run(1, 1'b0, 6'h2F, 6'h2F, 6'h00, 1'b0);
        // Simultaneous toggle of bits 0 and 4; resulting 110 pattern faults later.
        add_run(5, 1'b0, 6'h3E, 6'h2F, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h3E, 6'h3E, 6'h11, 1'b0);
        add_run(2, 1'b0, 6'h3E, 6'h3E, 6'h00, 1'b0);
        add_run(1, 1'b0, 6'h3E, 6'h3E, 6'h00, 1'b1);

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].rst, vecs[i].raw);
            $display("vec %0d rst=%0b raw=0x%02h stable=0x%02h change=0x%02h fault=%0b",
                     i, vecs[i].rst, vecs[i].raw, stable_o, change_o, level_fault_o);
            check6($sformatf("vec%0d_stable", i), stable_o, vecs[i].exp_stable);
            check6($sformatf("vec%0d_change", i), change_o, vecs[i].exp_change);
            check1($sformatf("vec%0d_fault", i), level_fault_o, vecs[i].exp_fault);
        end

        // Reset in the middle of a debounce run on middle_level.
        step(1'b1, 6'h00);
        check6("mid_rst_clear", stable_o, 6'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h02);
            check6($sformatf("mid_pre%0d_stable", i), stable_o, 6'h00);
        end
        step(1'b1, 6'h02);
        $display("mid-run reset stable=0x%02h change=0x%02h fault=%0b",
                 stable_o, change_o, level_fault_o);
        check6("mid_rst_stable", stable_o, 6'h00);
        check6("mid_rst_change", change_o, 6'h00);
        check1("mid_rst_fault", level_fault_o, 1'b0);

        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 6'h02);
            if (stable_o[1] === 1'b1) begin
                lat = i;
                break;
            end
        end
        $display("post-reset latency for middle_level: %0d edges", lat);
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL mid_latency: got %0d edges expected 6", lat);
        end
        check6("mid_accept_change", change_o, 6'h02);
        step(1'b0, 6'h02);
        check6("mid_after_change", change_o, 6'h00);
        check6("mid_after_stable", stable_o, 6'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
